vedic_mul9_pipe: RTL and testbench
==================================

VEDIC_MUL9_PIPE -- requirements
Module: vedic_mul9_pipe

Interface
REQ-001 Parameters: none; operand width fixed at 9 bits, product width at 18 bits, latency at 3 cycles.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 a  input  9  unsigned multiplicand, from buf4 a1 output.
REQ-005 b  input  9  unsigned multiplier, from buf4 b1 output.
REQ-006 in_valid  input  1  a/b hold a valid operand pair this cycle.
REQ-007 in_ready  output  1  block accepts the operand pair this cycle.
REQ-008 p  output  18  unsigned product a*b.
REQ-009 out_valid  output  1  p holds a valid product.
REQ-010 out_ready  input  1  downstream accepts p this cycle.

Function
REQ-011 Operands SHALL be split into base-8 digits: a = {a2,a1,a0}, b = {b2,b1,b0}, 3 bits each.
REQ-012 Stage 1 SHALL register all nine 6-bit digit products pij = ai*bj, plus valid bit v1.
REQ-013 Stage 2 SHALL register the Urdhva-Tiryagbhyam column sums plus valid bit v2: c0=p00 (6b), c1=p01+p10 (7b), c2=p02+p11+p20 (8b), c3=p12+p21 (7b), c4=p22 (6b).
REQ-014 Stage 3 SHALL register p = c0 + (c1<<3) + (c2<<6) + (c3<<9) + (c4<<12), truncated to 18 bits, and out_valid = v2.
REQ-015 No intermediate sum SHALL overflow its stated width; the 18-bit result SHALL equal the exact product for all 2^18 input pairs.
REQ-016 Pipeline SHALL advance when adv = !out_valid | out_ready; when adv=0 all stage registers and valid bits SHALL hold.
REQ-017 in_ready SHALL equal adv (combinational from out_valid and out_ready only; no path from in_valid).
REQ-018 A transfer occurs on in_valid & in_ready; on advance with in_valid=0 a bubble (v1=0) SHALL enter stage 1.
REQ-019 Latency SHALL be 3 cycles from accepted input to out_valid with no stall; throughput one product per cycle.
REQ-020 p and out_valid SHALL hold stable while out_valid & !out_ready.
REQ-021 Data registers of invalid stages MAY update freely; p SHALL NOT be relied on when out_valid=0.

Reset
REQ-022 On rst_n=0, v1, v2 and out_valid SHALL clear to 0 immediately, independent of clk.
REQ-023 On rst_n=0, p SHALL clear to 0; stage-1/2 data registers need no reset.
REQ-024 Reset mid-operation SHALL discard all in-flight pairs; no product from before reset SHALL appear afterwards.
REQ-025 First transfer SHALL be possible on the first rising edge after rst_n deasserts (in_ready=1 since out_valid=0).

Structure
REQ-026 Shared package vedic_pkg SHALL hold OPW=9, DIGW=3, PW=18, MUL_LAT=3.
REQ-027 One sub-module vedic_3x3 (3-bit x 3-bit combinational digit multiplier, 6-bit output) SHALL be instantiated nine times in stage 1.
REQ-028 Column adders and final adder SHALL be inline; no other sub-modules.

Verification
REQ-029 a=511, b=511, single pair, out_ready=1 -> out_valid high exactly 3 cycles later, p=261121 (0x3FC01).
REQ-030 Back-to-back pairs (0,37),(1,1),(255,2),(300,400) -> consecutive cycles p=0,1,510,120000, no gaps.
REQ-031 Stream of 4 pairs, out_ready=0 for 5 cycles once out_valid rises -> in_ready=0, p frozen, resume yields all 4 products in order, none lost or duplicated.
REQ-032 rst_n pulsed low with 3 pairs in flight -> out_valid drops asynchronously, p=0, no stale product after release.
REQ-033 Exhaustive 512x512 sweep with random in_valid/out_ready -> every p matches reference model a*b in order.

Source files
------------

// File: rtl/vedic_pkg.sv
// Shared widths for the 9x9 Urdhva-Tiryagbhyam pipelined multiplier.
package vedic_pkg;

  localparam int OPW     = 9;          // operand width
  localparam int DIGW    = 3;          // base-8 digit width
  localparam int PW      = 18;         // product width
  localparam int MUL_LAT = 3;          // input-to-output latency in cycles
  localparam int NDIG    = OPW / DIGW; // digits per operand
  localparam int PPW     = 2 * DIGW;   // digit-product width

  typedef logic [PPW-1:0] pp_t;

endpackage

// File: rtl/vedic_3x3.sv
// Combinational 3-bit x 3-bit digit multiplier; the leaf cell of the vertical-crosswise array.
module vedic_3x3
  import vedic_pkg::*;
(
  input  logic [DIGW-1:0] i_x,
  input  logic [DIGW-1:0] i_y,
  output logic [PPW-1:0]  o_prod
);

  // Widen before multiplying so the full 6-bit product is kept.
  assign o_prod = PPW'(i_x) * PPW'(i_y);

endmodule

// File: rtl/vedic_mul9_pipe.sv
// 9x9 unsigned multiplier, three pipeline stages:
//   stage 1: nine digit products, stage 2: column sums, stage 3: weighted final sum.
// Handshake: a pair transfers on in_valid & in_ready and a product on out_valid & out_ready.
// The whole pipe moves together on adv = !out_valid | out_ready; in_ready is adv, so it
// never depends on in_valid, and while the output is stalled every stage holds.
module vedic_mul9_pipe
  import vedic_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] b,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [PW-1:0]  p,
  output logic           out_valid,
  input  logic           out_ready
);

  logic                           w_adv;
  pp_t [NDIG-1:0][NDIG-1:0]       w_pp;     // w_pp[i][j] = a_i * b_j
  pp_t [NDIG-1:0][NDIG-1:0]       r_pp;
  logic                           r_v1;

  logic [PPW-1:0]                 w_c0;
  logic [PPW:0]                   w_c1;
  logic [PPW+1:0]                 w_c2;
  logic [PPW:0]                   w_c3;
  logic [PPW-1:0]                 w_c4;
  logic [PPW-1:0]                 r_c0;
  logic [PPW:0]                   r_c1;
  logic [PPW+1:0]                 r_c2;
  logic [PPW:0]                   r_c3;
  logic [PPW-1:0]                 r_c4;
  logic                           r_v2;

  logic [PW-1:0]                  w_sum;
  logic [PW-1:0]                  r_p;
  logic                           r_out_valid;

  assign w_adv    = !r_out_valid || out_ready;
  assign in_ready = w_adv;

  // Nine digit multipliers: digit i of a against digit j of b.
  for (genvar gi = 0; gi < NDIG; gi++) begin : g_row
    for (genvar gj = 0; gj < NDIG; gj++) begin : g_col
      vedic_3x3 u_mul (
        .i_x    (a[gi*DIGW +: DIGW]),
        .i_y    (b[gj*DIGW +: DIGW]),
        .o_prod (w_pp[gi][gj])
      );
    end
  end

  // Stage 1 data: digit products; no reset needed since v1 qualifies them.
  always_ff @(posedge clk) begin
    if (w_adv) r_pp <= w_pp;
  end

  // Stage 1 valid: a bubble enters whenever the pipe advances without a pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_v1 <= 1'b0;
    else if (w_adv) r_v1 <= in_valid;
  end

  // Crosswise column sums; each width holds the worst case 49 per term.
  assign w_c0 = r_pp[0][0];
  assign w_c1 = (PPW+1)'(r_pp[0][1]) + (PPW+1)'(r_pp[1][0]);
  assign w_c2 = (PPW+2)'(r_pp[0][2]) + (PPW+2)'(r_pp[1][1]) + (PPW+2)'(r_pp[2][0]);
  assign w_c3 = (PPW+1)'(r_pp[1][2]) + (PPW+1)'(r_pp[2][1]);
  assign w_c4 = r_pp[2][2];

  // Stage 2 data: column sums.
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_c0 <= w_c0;
      r_c1 <= w_c1;
      r_c2 <= w_c2;
      r_c3 <= w_c3;
      r_c4 <= w_c4;
    end
  end

  // Stage 2 valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_v2 <= 1'b0;
    else if (w_adv) r_v2 <= r_v1;
  end

  // Column k carries weight 8^k; the exact product fits in 18 bits.
  assign w_sum = PW'(r_c0)
               + (PW'(r_c1) << DIGW)
               + (PW'(r_c2) << (2*DIGW))
               + (PW'(r_c3) << (3*DIGW))
               + (PW'(r_c4) << (4*DIGW));

  // Stage 3: registered product and output valid, both cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p         <= '0;
      r_out_valid <= 1'b0;
    end else if (w_adv) begin
      r_p         <= w_sum;
      r_out_valid <= r_v2;
    end
  end

  assign p         = r_p;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_vedic_mul9_pipe.sv
// Directed bench for vedic_mul9_pipe: latency, streaming, stall, reset, randomized stream.
module tb_vedic_mul9_pipe;
  import vedic_pkg::*;

  logic           clk;
  logic           rst_n;
  logic [OPW-1:0] a;
  logic [OPW-1:0] b;
  logic           in_valid;
  logic           in_ready;
  logic [PW-1:0]  p;
  logic           out_valid;
  logic           out_ready;

  int pass_cnt;
  int fail_cnt;
  int total_cnt;

  logic [PW-1:0] exp_q[$];

  vedic_mul9_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .p         (p),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic v, input logic [OPW-1:0] av, input logic [OPW-1:0] bv);
    in_valid = v;
    a        = av;
    b        = bv;
  endtask

  // Directed vectors with hand-computed products
  logic [OPW-1:0] s_a [4];
  logic [OPW-1:0] s_b [4];
  logic [PW-1:0]  s_p [4];

  initial begin
    logic [PW-1:0] hold_p;
    logic          hold_chk;
    logic [PW-1:0] got;
    int            sel;

    pass_cnt  = 0;
    fail_cnt  = 0;
    total_cnt = 0;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, '0, '0);

    // Reset state
    #12;
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset p", 32'(p), 0);
    chk("reset in_ready", 32'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single pair 511*511, latency 3
    drive(1'b1, 9'd511, 9'd511);
    for (int c = 1; c <= MUL_LAT; c++) begin
      step();
      drive(1'b0, '0, '0);
      chk($sformatf("latency ov c%0d", c), 32'(out_valid), (c == MUL_LAT) ? 1 : 0);
    end
    chk("511x511 p", 32'(p), 32'd261121);
    step();
    chk("after single ov", 32'(out_valid), 0);

    // Back-to-back stream, no gaps
    s_a = '{9'd0, 9'd1, 9'd255, 9'd300};
    s_b = '{9'd37, 9'd1, 9'd2, 9'd400};
    s_p = '{18'd0, 18'd1, 18'd510, 18'd120000};
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drive(1'b1, s_a[i], s_b[i]);
      else       drive(1'b0, '0, '0);
      step();
      if (i >= 2) begin
        chk($sformatf("b2b ov %0d", i), 32'(out_valid), 1);
        chk($sformatf("b2b p %0d", i - 2), 32'(p), 32'(s_p[i-2]));
      end else begin
        chk($sformatf("b2b fill ov %0d", i), 32'(out_valid), 0);
      end
    end
    drive(1'b0, '0, '0);
    step();
    chk("b2b tail ov", 32'(out_valid), 0);

    // Stall for 5 cycles once the first product is out
    s_a = '{9'd3, 9'd100, 9'd511, 9'd7};
    s_b = '{9'd5, 9'd200, 9'd1, 9'd64};
    s_p = '{18'd15, 18'd20000, 18'd511, 18'd448};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, s_a[i], s_b[i]);
      step();
    end
    chk("stall first ov", 32'(out_valid), 1);
    chk("stall first p", 32'(p), 32'(s_p[0]));
    drive(1'b1, s_a[3], s_b[3]);
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("stall in_ready %0d", c), 32'(in_ready), 0);
      chk($sformatf("stall p %0d", c), 32'(p), 32'(s_p[0]));
      chk($sformatf("stall ov %0d", c), 32'(out_valid), 1);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("resume in_ready", 32'(in_ready), 1);
    step();
    drive(1'b0, '0, '0);
    for (int i = 1; i < 4; i++) begin
      chk($sformatf("resume ov %0d", i), 32'(out_valid), 1);
      chk($sformatf("resume p %0d", i), 32'(p), 32'(s_p[i]));
      step();
    end
    chk("resume tail ov", 32'(out_valid), 0);

    // Reset with three pairs in flight
    drive(1'b1, 9'd10, 9'd10);
    step();
    drive(1'b1, 9'd20, 9'd20);
    step();
    drive(1'b1, 9'd30, 9'd30);
    step();
    drive(1'b0, '0, '0);
    chk("pre-reset p", 32'(p), 32'd100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset ov", 32'(out_valid), 0);
    chk("async reset p", 32'(p), 0);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    drive(1'b1, 9'd5, 9'd6);
    for (int c = 1; c <= MUL_LAT; c++) begin
      step();
      drive(1'b0, '0, '0);
      chk($sformatf("post-reset ov c%0d", c), 32'(out_valid), (c == MUL_LAT) ? 1 : 0);
    end
    chk("post-reset p", 32'(p), 32'd30);
    step();
    chk("post-reset tail ov", 32'(out_valid), 0);

    // Randomized stream with random in_valid/out_ready, scoreboard on a*b
    hold_chk = 1'b0;
    hold_p   = '0;
    for (int c = 0; c < 1500; c++) begin
      sel = $urandom_range(0, 7);
      a = (sel == 0) ? 9'd0 : (sel == 1) ? 9'd511 : 9'($urandom_range(0, 511));
      sel = $urandom_range(0, 7);
      b = (sel == 0) ? 9'd0 : (sel == 1) ? 9'd511 : 9'($urandom_range(0, 511));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      if (hold_chk) begin
        chk("hold ov", 32'(out_valid), 1);
        chk("hold p", 32'(p), 32'(hold_p));
      end
      if (in_valid && in_ready) exp_q.push_back(PW'(a) * PW'(b));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected product", 32'(p), 32'hFFFF_FFFF);
        else begin
          got = exp_q.pop_front();
          chk("stream p", 32'(p), 32'(got));
        end
      end
      hold_chk = out_valid && !out_ready;
      hold_p   = p;
      step();
    end

    // Drain with a bounded cycle budget
    drive(1'b0, '0, '0);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
      #1;
      if (out_valid) begin
        got = exp_q.pop_front();
        chk("drain p", 32'(p), 32'(got));
      end
      step();
    end
    chk("drain queue empty", 32'(exp_q.size()), 0);
    step();
    chk("final ov", 32'(out_valid), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
